// File: rtl/if_stage_pkg.sv
// Shared constants and state encodings for the instruction-fetch stage
// and the pipeline registers that sit behind it.
package if_stage_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_KILL = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Generic valid/pc/pcplus4/instr pipeline register with hold and bubble
// controls; a bubble clears valid and parks a nop in the instruction slot.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int AW = 32,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          bubble,
    input  logic [AW-1:0] in_pc,
    input  logic [IW-1:0] in_instr,
    output logic          out_valid,
    output logic [AW-1:0] out_pc,
    output logic [AW-1:0] out_pcplus4,
    output logic [IW-1:0] out_instr
);

    logic          valid_q, valid_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] pcplus4_q, pcplus4_d;
    logic [IW-1:0] instr_q, instr_d;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        instr_d   = instr_q;
        if (!hold) begin
            if (bubble) begin
                valid_d = 1'b0;
                instr_d = IW'(INSTR_NOP);
            end else begin
                valid_d   = 1'b1;
                pc_d      = in_pc;
                pcplus4_d = in_pc + AW'(4);
                instr_d   = in_instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            pcplus4_q <= AW'(4);
            instr_q   <= IW'(INSTR_NOP);
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            instr_q   <= instr_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_pcplus4 = pcplus4_q;
    assign out_instr   = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, runs the imem request/ready handshake,
// and feeds the IF/ID register while absorbing stalls and redirects.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   id_valid,
    output logic [ADDR_WIDTH-1:0]  id_pc,
    output logic [ADDR_WIDTH-1:0]  id_pcplus4,
    output logic [INSTR_WIDTH-1:0] id_instr
);

    if_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  tgt_q, tgt_d;
    logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;

    logic                   accept;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic [ADDR_WIDTH-1:0]  redir_aligned;
    logic                   ifid_hold;
    logic                   ifid_bubble;
    logic [ADDR_WIDTH-1:0]  ifid_pc;
    logic [INSTR_WIDTH-1:0] ifid_instr;

    // HOLD is the only state without an outstanding request, so the address
    // can never move under a pending fetch.
    assign imem_req      = (state_q != S_HOLD);
    assign imem_addr     = pc_q;
    assign accept        = imem_req & imem_ready;
    assign pc_next       = pc_q + ADDR_WIDTH'(4);
    assign redir_aligned = redirect_pc & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_hold    = 1'b1;
        ifid_bubble  = 1'b0;
        ifid_pc      = pc_q;
        ifid_instr   = imem_rdata;
        unique case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (redirect) begin
                        pc_d        = redir_aligned;
                        ifid_hold   = 1'b0;
                        ifid_bubble = 1'b1;
                    end else if (stall) begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        pc_d         = pc_next;
                        state_d      = S_HOLD;
                    end else begin
                        pc_d      = pc_next;
                        ifid_hold = 1'b0;
                    end
                end else if (redirect) begin
                    // The pending fetch must complete before the PC may move.
                    tgt_d       = redir_aligned;
                    ifid_hold   = 1'b0;
                    ifid_bubble = 1'b1;
                    state_d     = S_KILL;
                end else if (!stall) begin
                    ifid_hold   = 1'b0;
                    ifid_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d        = redir_aligned;
                    ifid_hold   = 1'b0;
                    ifid_bubble = 1'b1;
                    state_d     = S_RUN;
                end else if (!stall) begin
                    ifid_hold  = 1'b0;
                    ifid_pc    = skid_pc_q;
                    ifid_instr = skid_instr_q;
                    state_d    = S_RUN;
                end
            end
            S_KILL: begin
                ifid_hold   = 1'b0;
                ifid_bubble = 1'b1;
                if (redirect) begin
                    tgt_d = redir_aligned;
                end
                if (accept) begin
                    pc_d    = redirect ? redir_aligned : tgt_q;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // Skid contents are only consumed in HOLD, which reset never leaves us in.
    always_ff @(posedge clk) begin
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

    if_id_reg #(
        .AW(ADDR_WIDTH),
        .IW(INSTR_WIDTH)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .hold       (ifid_hold),
        .bubble     (ifid_bubble),
        .in_pc      (ifid_pc),
        .in_instr   (ifid_instr),
        .out_valid  (id_valid),
        .out_pc     (id_pc),
        .out_pcplus4(id_pcplus4),
        .out_instr  (id_instr)
    );

endmodule
